nios_upc_dbg_scan_decoder: RTL and testbench
============================================

Name: nios_upc_dbg_scan_decoder

Overview:
- Parametrised successor to the fixed 2-bit-IR / 38-bit-DR debug scan path, running entirely in the system clock domain.
- Latches a virtual-IR channel select and captures per-channel readback words into a shift register, then shifts them out serially.
- On update, publishes the shifted-in word and raises a held per-channel action/no-action request until the consumer acknowledges it.
- Sits between the virtual-JTAG strobe synchroniser and the CPU debug/OCI logic.

Parameters:
- DR_WIDTH, 38: data/shift register width in bits (min 4).
- IR_WIDTH, 2: channel-select width; NUM_CH = 2**IR_WIDTH.
- ACT_BIT, 35: index of the shift-register bit selecting action (1) or no-action (0); must be < DR_WIDTH.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ir_in  in  IR_WIDTH  channel select; sampled when uir is high.
- uir  in  1  update-IR strobe, one clk per event.
- cdr  in  1  capture-DR strobe.
- sdr  in  1  shift enable, one bit per clk while high.
- tdi  in  1  serial data in.
- tdo  out  1  serial data out; equals sr[0].
- rd_data  in  NUM_CH*DR_WIDTH  readback words; channel k occupies bits [k*DR_WIDTH +: DR_WIDTH].
- udr  in  1  update-DR strobe.
- jdo  out  DR_WIDTH  published data word.
- take_action  out  NUM_CH  request, held high until acknowledged.
- take_no_action  out  NUM_CH  request, held high until acknowledged.
- ack  in  1  consumer accepts the outstanding request.
- busy  out  1  a request is outstanding.
- ovr  out  1  sticky overrun flag.
- ovr_clr  in  1  clears ovr.
- ir_q  out  IR_WIDTH  currently latched channel.

Behaviour:

Reset (sync, active-high):
- ir_q, sr, jdo, take_action, take_no_action, busy, ovr all 0.
- reset has priority over every other input.
- reset asserted mid-shift or while a request is pending discards all state; no request survives.

IR latch:
- uir=1: ir_q <= ir_in on the next edge.
- A uir during a pending request does not alter the pending channel; the channel is latched separately as act_ch at update.

Shift register sr (priority cdr > sdr):
- cdr=1: sr <= rd_data slice ir_q (the value of ir_q before the edge).
- Else sdr=1: sr <= {tdi, sr[DR_WIDTH-1:1]} (LSB out first).
- tdo is combinational sr[0]; zero latency.
- cdr and sdr together: the capture wins and no shift occurs that cycle.

Update (udr=1) when busy=0 or ack=1 in the same cycle:
- jdo <= sr; act_ch <= ir_q; busy <= 1.
- take_action[ir_q] <= sr[ACT_BIT]; take_no_action[ir_q] <= ~sr[ACT_BIT].
- All other request bits are 0.
- Exactly one of the 2*NUM_CH request bits is high whenever busy=1.
- Requests appear on the edge after udr (latency 1).

Update when busy=1 and ack=0:
- The update is dropped: jdo and the requests are unchanged.
- ovr <= 1.

Acknowledge:
- ack=1 with busy=1 clears busy and all request bits on the next edge.
- ack with busy=0 is ignored.
- ack and udr in the same cycle: the new request is accepted and replaces the old one; busy stays 1 and ovr is unchanged.

Overrun flag:
- ovr_clr=1 clears ovr.
- If ovr_clr and an overrun occur in the same cycle, set wins.

Other rules:
- jdo holds its value across ack; it changes only on an accepted update or reset.
- udr and cdr together: the update uses sr before the capture, and the capture proceeds in the same cycle.

Test Plan:
1. Capture and shift-out: reset; ir_in=2 with uir; rd_data ch2 = 38'h2A_5A5A_5A5A; cdr; 38 cycles of sdr with tdi=0 -> tdo emits the word LSB first (0,1,0,1,1,0,...); sr ends at 0.
2. Shift-in and action: ir=1; shift in 38'h08_0000_1234 (bit35=1); udr -> next cycle jdo=38'h08_0000_1234, take_action=4'b0010, take_no_action=0, busy=1. ack -> next cycle all requests 0, busy=0, jdo unchanged.
3. No-action path: ir=3; word 38'h00_DEAD_BEEF (bit35=0); udr -> take_no_action=4'b1000, take_action=0.
4. Overrun: while busy from scenario 2, shift a new word and udr without ack -> jdo unchanged, ovr=1. ovr_clr -> ovr=0. Assert ovr_clr and a second dropped udr in the same cycle -> ovr=1.
5. Simultaneous ack+udr: pending ch1 action; ack and udr (ir=0, bit35=0) in the same cycle -> next cycle take_no_action=4'b0001, take_action=0, busy=1, ovr=0.
6. Reset mid-operation and priority: reset during shift with busy=1 -> next cycle every output 0. Then cdr and sdr together -> sr equals the captured word, not shifted. Rerun with IR_WIDTH=3, DR_WIDTH=16, ACT_BIT=15 -> channel 7 request decoded correctly.

Source files
------------

// File: rtl/nios_upc_dbg_scan_decoder_if.sv
// Scan-path bus between the virtual-JTAG strobe synchroniser (master) and the
// scan decoder (slave): strobes, serial data, readback words and requests.
interface nios_upc_dbg_scan_decoder_if #(
    parameter int DR_WIDTH = 38,
    parameter int IR_WIDTH = 2
);
    localparam int NUM_CH = 2 ** IR_WIDTH;

    logic [IR_WIDTH-1:0]        ir_in;
    logic                       uir;
    logic                       cdr;
    logic                       sdr;
    logic                       tdi;
    logic                       tdo;
    logic [NUM_CH*DR_WIDTH-1:0] rd_data;
    logic                       udr;
    logic [DR_WIDTH-1:0]        jdo;
    logic [NUM_CH-1:0]          take_action;
    logic [NUM_CH-1:0]          take_no_action;
    logic                       ack;
    logic                       busy;
    logic                       ovr;
    logic                       ovr_clr;
    logic [IR_WIDTH-1:0]        ir_q;

    modport master (
        output ir_in, uir, cdr, sdr, tdi, rd_data, udr, ack, ovr_clr,
        input  tdo, jdo, take_action, take_no_action, busy, ovr, ir_q
    );

    modport slave (
        input  ir_in, uir, cdr, sdr, tdi, rd_data, udr, ack, ovr_clr,
        output tdo, jdo, take_action, take_no_action, busy, ovr, ir_q
    );
endinterface

// File: rtl/nios_upc_dbg_scan_decoder.sv
// Debug scan decoder: latches a channel select, captures/shifts a readback word,
// and publishes updates as held action/no-action requests with overrun detection.
module nios_upc_dbg_scan_decoder #(
    parameter int DR_WIDTH = 38,
    parameter int IR_WIDTH = 2,
    parameter int ACT_BIT  = 35
) (
    input  logic                           clk,
    input  logic                           reset,
    nios_upc_dbg_scan_decoder_if.slave     bus
);
    localparam int NUM_CH = 2 ** IR_WIDTH;

    logic [IR_WIDTH-1:0] ir_q;
    logic [DR_WIDTH-1:0] sr;
    logic [DR_WIDTH-1:0] jdo;
    logic [DR_WIDTH-1:0] cap_word;
    logic [NUM_CH-1:0]   ch_onehot;
    logic [NUM_CH-1:0]   take_action;
    logic [NUM_CH-1:0]   take_no_action;
    logic                busy;
    logic                ovr;
    logic                accept;
    logic                overrun;

    // Readback mux and channel decode, both driven by the pre-edge ir_q.
    always_comb begin
        cap_word  = '0;
        ch_onehot = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ir_q == k[IR_WIDTH-1:0]) begin
                cap_word     = bus.rd_data[k*DR_WIDTH +: DR_WIDTH];
                ch_onehot[k] = 1'b1;
            end
        end
    end

    // An ack in the same cycle frees the slot, so the new update replaces the old one.
    assign accept  = bus.udr && (!busy || bus.ack);
    assign overrun = bus.udr && busy && !bus.ack;

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the shift register is reset with everything else so no stale
            // word can be published or shifted out after a mid-operation reset.
            ir_q           <= '0;
            sr             <= '0;
            jdo            <= '0;
            take_action    <= '0;
            take_no_action <= '0;
            busy           <= 1'b0;
            ovr            <= 1'b0;
        end else begin
            if (bus.uir) begin
                ir_q <= bus.ir_in;
            end

            if (bus.cdr) begin
                sr <= cap_word;
            end else if (bus.sdr) begin
                sr <= {bus.tdi, sr[DR_WIDTH-1:1]};
            end

            // The request vectors themselves hold the channel latched at update,
            // so a later uir cannot retarget a pending request.
            if (accept) begin
                jdo            <= sr;
                busy           <= 1'b1;
                take_action    <= sr[ACT_BIT] ? ch_onehot : '0;
                take_no_action <= sr[ACT_BIT] ? '0 : ch_onehot;
            end else if (bus.ack && busy) begin
                busy           <= 1'b0;
                take_action    <= '0;
                take_no_action <= '0;
            end

            if (overrun) begin
                ovr <= 1'b1;
            end else if (bus.ovr_clr) begin
                ovr <= 1'b0;
            end
        end
    end

    assign bus.tdo            = sr[0];
    assign bus.jdo            = jdo;
    assign bus.take_action    = take_action;
    assign bus.take_no_action = take_no_action;
    assign bus.busy           = busy;
    assign bus.ovr            = ovr;
    assign bus.ir_q           = ir_q;
endmodule

// File: tb/tb_nios_upc_dbg_scan_decoder.sv
// Directed bench for the scan decoder: default 38-bit/4-channel instance plus a
// 16-bit/8-channel instance for the channel-7 decode.
module tb_nios_upc_dbg_scan_decoder;
    localparam int DW  = 38;
    localparam int IW  = 2;
    localparam int NC  = 4;
    localparam int DWB = 16;
    localparam int IWB = 3;
    localparam int NCB = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    nios_upc_dbg_scan_decoder_if #(.DR_WIDTH(DW),  .IR_WIDTH(IW))  bus_a ();
    nios_upc_dbg_scan_decoder_if #(.DR_WIDTH(DWB), .IR_WIDTH(IWB)) bus_b ();

    nios_upc_dbg_scan_decoder #(.DR_WIDTH(DW), .IR_WIDTH(IW), .ACT_BIT(35)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    nios_upc_dbg_scan_decoder #(.DR_WIDTH(DWB), .IR_WIDTH(IWB), .ACT_BIT(15)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled at the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_ir_a(input logic [IW-1:0] ch);
        bus_a.ir_in = ch;
        bus_a.uir   = 1'b1;
        tick();
        bus_a.uir   = 1'b0;
    endtask

    task automatic shift_in_a(input logic [DW-1:0] w);
        for (int i = 0; i < DW; i++) begin
            bus_a.sdr = 1'b1;
            bus_a.tdi = w[i];
            tick();
        end
        bus_a.sdr = 1'b0;
        bus_a.tdi = 1'b0;
    endtask

    task automatic udr_a();
        bus_a.udr = 1'b1;
        tick();
        bus_a.udr = 1'b0;
    endtask

    task automatic ack_a();
        bus_a.ack = 1'b1;
        tick();
        bus_a.ack = 1'b0;
    endtask

    localparam logic [DW-1:0] W1 = 38'h2A_5A5A_5A5A;
    localparam logic [DW-1:0] W2 = 38'h08_0000_1234;
    localparam logic [DW-1:0] W3 = 38'h3F_FFFF_0000;
    localparam logic [DW-1:0] W4 = 38'h00_DEAD_BEEF;
    localparam logic [DW-1:0] W5 = 38'h00_0000_00A5;
    localparam logic [DW-1:0] W6 = 38'h15_0F0F_0F0F;
    localparam logic [DW-1:0] W7 = 38'h20_0000_0003;

    logic [DW-1:0] got_word;

    initial begin
        reset = 1'b1;
        {bus_a.ir_in, bus_a.uir, bus_a.cdr, bus_a.sdr, bus_a.tdi} = '0;
        {bus_a.udr, bus_a.ack, bus_a.ovr_clr} = '0;
        bus_a.rd_data = '0;
        {bus_b.ir_in, bus_b.uir, bus_b.cdr, bus_b.sdr, bus_b.tdi} = '0;
        {bus_b.udr, bus_b.ack, bus_b.ovr_clr} = '0;
        bus_b.rd_data = '0;
        @(negedge clk);
        tick();
        tick();
        reset = 1'b0;

        check("rst_jdo",  64'(bus_a.jdo), 64'h0);
        check("rst_busy", 64'(bus_a.busy), 64'h0);
        check("rst_req",  64'({bus_a.take_action, bus_a.take_no_action}), 64'h0);
        check("rst_ovr",  64'(bus_a.ovr), 64'h0);

        // Capture channel 2 and shift it out LSB first.
        set_ir_a(2'd2);
        check("ir_q_2", 64'(bus_a.ir_q), 64'd2);
        bus_a.rd_data[2*DW +: DW] = W1;
        bus_a.cdr = 1'b1;
        tick();
        bus_a.cdr = 1'b0;
        check("cap_tdo0", 64'(bus_a.tdo), 64'(W1[0]));
        for (int i = 0; i < DW; i++) begin
            got_word[i] = bus_a.tdo;
            bus_a.sdr = 1'b1;
            bus_a.tdi = 1'b0;
            tick();
        end
        bus_a.sdr = 1'b0;
        check("shift_out", 64'(got_word), 64'(W1));
        check("sr_empty_tdo", 64'(bus_a.tdo), 64'h0);
        udr_a();
        check("sr_empty_jdo", 64'(bus_a.jdo), 64'h0);
        check("empty_tna",    64'(bus_a.take_no_action), 64'b0100);
        ack_a();
        ack_a();
        check("ack_idle_busy", 64'(bus_a.busy), 64'h0);
        check("ack_idle_req",  64'({bus_a.take_action, bus_a.take_no_action}), 64'h0);

        // Shift-in and action on channel 1.
        set_ir_a(2'd1);
        shift_in_a(W2);
        check("pre_udr_busy", 64'(bus_a.busy), 64'h0);
        udr_a();
        check("act_jdo",  64'(bus_a.jdo), 64'(W2));
        check("act_ta",   64'(bus_a.take_action), 64'b0010);
        check("act_tna",  64'(bus_a.take_no_action), 64'h0);
        check("act_busy", 64'(bus_a.busy), 64'h1);
        ack_a();
        check("ack_req",  64'({bus_a.take_action, bus_a.take_no_action}), 64'h0);
        check("ack_busy", 64'(bus_a.busy), 64'h0);
        check("ack_jdo",  64'(bus_a.jdo), 64'(W2));

        // Overrun while the channel-1 request is pending.
        udr_a();
        check("repend_ta", 64'(bus_a.take_action), 64'b0010);
        shift_in_a(W3);
        udr_a();
        check("ovr_jdo", 64'(bus_a.jdo), 64'(W2));
        check("ovr_set", 64'(bus_a.ovr), 64'h1);
        check("ovr_ta",  64'(bus_a.take_action), 64'b0010);
        bus_a.ovr_clr = 1'b1;
        tick();
        check("ovr_clr", 64'(bus_a.ovr), 64'h0);
        bus_a.udr = 1'b1;
        tick();
        bus_a.udr = 1'b0;
        bus_a.ovr_clr = 1'b0;
        check("ovr_set_wins", 64'(bus_a.ovr), 64'h1);
        check("ovr_jdo2",     64'(bus_a.jdo), 64'(W2));

        // Simultaneous ack and udr; uir during pending does not retarget.
        bus_a.ovr_clr = 1'b1;
        tick();
        bus_a.ovr_clr = 1'b0;
        check("ovr_clr2", 64'(bus_a.ovr), 64'h0);
        set_ir_a(2'd0);
        check("uir_pending_ta", 64'(bus_a.take_action), 64'b0010);
        shift_in_a(W5);
        bus_a.ack = 1'b1;
        bus_a.udr = 1'b1;
        tick();
        bus_a.ack = 1'b0;
        bus_a.udr = 1'b0;
        check("ackudr_tna",  64'(bus_a.take_no_action), 64'b0001);
        check("ackudr_ta",   64'(bus_a.take_action), 64'h0);
        check("ackudr_busy", 64'(bus_a.busy), 64'h1);
        check("ackudr_ovr",  64'(bus_a.ovr), 64'h0);
        check("ackudr_jdo",  64'(bus_a.jdo), 64'(W5));
        ack_a();

        // No-action path on channel 3.
        set_ir_a(2'd3);
        shift_in_a(W4);
        udr_a();
        check("noact_tna", 64'(bus_a.take_no_action), 64'b1000);
        check("noact_ta",  64'(bus_a.take_action), 64'h0);
        check("noact_jdo", 64'(bus_a.jdo), 64'(W4));

        // Reset mid-shift with a request pending and ovr set.
        udr_a();
        check("pre_rst_ovr", 64'(bus_a.ovr), 64'h1);
        bus_a.sdr = 1'b1;
        bus_a.tdi = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        bus_a.uir = 1'b1;
        bus_a.ir_in = 2'd2;
        bus_a.udr = 1'b1;
        tick();
        reset = 1'b0;
        {bus_a.uir, bus_a.udr, bus_a.sdr, bus_a.tdi} = '0;
        bus_a.ir_in = '0;
        check("midrst_jdo",  64'(bus_a.jdo), 64'h0);
        check("midrst_req",  64'({bus_a.take_action, bus_a.take_no_action}), 64'h0);
        check("midrst_busy", 64'(bus_a.busy), 64'h0);
        check("midrst_ovr",  64'(bus_a.ovr), 64'h0);
        check("midrst_irq",  64'(bus_a.ir_q), 64'h0);
        check("midrst_tdo",  64'(bus_a.tdo), 64'h0);

        // Capture beats shift when both are asserted.
        bus_a.rd_data = '0;
        bus_a.rd_data[0 +: DW] = W6;
        bus_a.cdr = 1'b1;
        bus_a.sdr = 1'b1;
        tick();
        {bus_a.cdr, bus_a.sdr} = '0;
        udr_a();
        check("cdr_sdr_jdo", 64'(bus_a.jdo), 64'(W6));
        check("cdr_sdr_tna", 64'(bus_a.take_no_action), 64'b0001);

        // Update with capture: publish pre-capture sr, capture still happens.
        bus_a.rd_data[0 +: DW] = W7;
        bus_a.ack = 1'b1;
        bus_a.udr = 1'b1;
        bus_a.cdr = 1'b1;
        tick();
        bus_a.cdr = 1'b0;
        check("udr_cdr_jdo", 64'(bus_a.jdo), 64'(W6));
        tick();
        bus_a.ack = 1'b0;
        bus_a.udr = 1'b0;
        check("udr_cdr_next", 64'(bus_a.jdo), 64'(W7));

        // Wider-IR instance: channel 7 decode.
        bus_b.ir_in = 3'd7;
        bus_b.uir = 1'b1;
        tick();
        bus_b.uir = 1'b0;
        check("b_irq", 64'(bus_b.ir_q), 64'd7);
        bus_b.rd_data[7*DWB +: DWB] = 16'h8001;
        bus_b.cdr = 1'b1;
        tick();
        bus_b.cdr = 1'b0;
        check("b_tdo", 64'(bus_b.tdo), 64'h1);
        bus_b.udr = 1'b1;
        tick();
        bus_b.udr = 1'b0;
        check("b_jdo", 64'(bus_b.jdo), 64'h8001);
        check("b_ta",  64'(bus_b.take_action), 64'h80);
        check("b_tna", 64'(bus_b.take_no_action), 64'h0);
        for (int i = 0; i < DWB; i++) begin
            bus_b.sdr = 1'b1;
            bus_b.tdi = 1'((16'h1234 >> i) & 1);
            tick();
        end
        bus_b.sdr = 1'b0;
        bus_b.tdi = 1'b0;
        bus_b.ack = 1'b1;
        bus_b.udr = 1'b1;
        tick();
        bus_b.ack = 1'b0;
        bus_b.udr = 1'b0;
        check("b_jdo2", 64'(bus_b.jdo), 64'h1234);
        check("b_tna2", 64'(bus_b.take_no_action), 64'h80);
        check("b_ta2",  64'(bus_b.take_action), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
